// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- / checkerboard / address-as-data BIST controller for one SRAM macro
module sram_march_bist #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int NUM_WMASKS    = 4,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic                     stop_on_fail_i,
    output logic                     sram_csb_o,
    output logic                     sram_web_o,
    output logic [NUM_WMASKS-1:0]    sram_wmask_o,
    output logic [ADDR_WIDTH-1:0]    sram_addr_o,
    output logic [DATA_WIDTH-1:0]    sram_din_o,
    input  logic [DATA_WIDTH-1:0]    sram_dout_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fail_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr_o,
    output logic [DATA_WIDTH-1:0]    first_fail_data_o
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] CB_PAT    = {(DATA_WIDTH/2){2'b01}};
    localparam int                    DCW       = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [1:0]              mode_q;
    logic                    stop_q;
    logic [2:0]              elem;
    logic                    sub;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DCW-1:0]          drain_cnt;
    logic                    rd_q;
    logic [DATA_WIDTH-1:0]   exp_q;
    logic                    pipe_vld  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];

    logic                    accept;
    logic                    mism;
    logic [1:0]              cur_mode;
    logic [2:0]              cur_elem;
    logic                    cur_sub;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    op_read;
    logic                    op_down;
    logic                    nxt_down;
    logic                    last_sub;
    logic                    last_elem;
    logic                    addr_end;
    logic [DATA_WIDTH-1:0]   op_data;

    assign accept       = start_i && (state == S_IDLE || state == S_DONE);
    assign mism         = pipe_vld[READ_LATENCY-1] && (sram_dout_i != pipe_exp[READ_LATENCY-1]);
    assign sram_wmask_o = '1;

    // The first op is issued on the accept edge, so decode from the incoming mode and zeroed counters.
    always_comb begin
        cur_mode  = accept ? ((mode_i == 2'd3) ? 2'd0 : mode_i) : mode_q;
        cur_elem  = accept ? 3'd0 : elem;
        cur_sub   = accept ? 1'b0 : sub;
        cur_addr  = accept ? '0 : addr;
        op_read   = 1'b0;
        op_down   = 1'b0;
        nxt_down  = 1'b0;
        last_sub  = 1'b1;
        last_elem = 1'b0;
        op_data   = '0;
        case (cur_mode)
            2'd1: begin
                op_read   = cur_elem[0];
                last_elem = (cur_elem == 3'd3);
                op_data   = CB_PAT ^ {DATA_WIDTH{cur_addr[0]}} ^ {DATA_WIDTH{cur_elem[1]}};
            end
            2'd2: begin
                op_read   = cur_elem[0];
                last_elem = (cur_elem == 3'd1);
                op_data   = DATA_WIDTH'(cur_addr);
            end
            default: begin
                op_read   = (cur_elem != 3'd0) && !cur_sub;
                last_sub  = (cur_elem == 3'd0) || (cur_elem == 3'd5) || cur_sub;
                last_elem = (cur_elem == 3'd5);
                op_down   = (cur_elem == 3'd3) || (cur_elem == 3'd4);
                nxt_down  = (cur_elem == 3'd2) || (cur_elem == 3'd3);
                op_data   = {DATA_WIDTH{((cur_elem == 3'd1) || (cur_elem == 3'd3)) ? cur_sub :
                                        ((cur_elem == 3'd2) || (cur_elem == 3'd4)) ? ~cur_sub : 1'b0}};
            end
        endcase
        addr_end = op_down ? (cur_addr == '0) : (cur_addr == LAST_ADDR);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state             <= S_IDLE;
            mode_q            <= 2'd0;
            stop_q            <= 1'b0;
            elem              <= 3'd0;
            sub               <= 1'b0;
            addr              <= '0;
            drain_cnt         <= '0;
            rd_q              <= 1'b0;
            exp_q             <= '0;
            sram_csb_o        <= 1'b1;
            sram_web_o        <= 1'b1;
            sram_addr_o       <= '0;
            sram_din_o        <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            fail_o            <= 1'b0;
            err_count_o       <= '0;
            first_fail_addr_o <= '0;
            first_fail_data_o <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_exp[i]  <= '0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_q;
            pipe_exp[0]  <= exp_q;
            pipe_addr[0] <= sram_addr_o;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
            rd_q       <= 1'b0;
            sram_csb_o <= 1'b1;
            sram_web_o <= 1'b1;

            if (accept) begin
                mode_q            <= cur_mode;
                stop_q            <= stop_on_fail_i;
                busy_o            <= 1'b1;
                done_o            <= 1'b0;
                fail_o            <= 1'b0;
                err_count_o       <= '0;
                first_fail_addr_o <= '0;
                first_fail_data_o <= '0;
            end else if (mism) begin
                if (err_count_o != '1)
                    err_count_o <= err_count_o + ERR_CNT_WIDTH'(1);
                if (!fail_o) begin
                    fail_o            <= 1'b1;
                    first_fail_addr_o <= pipe_addr[READ_LATENCY-1];
                    first_fail_data_o <= sram_dout_i;
                end
            end

            if (accept || (state == S_RUN && !(mism && stop_q))) begin
                sram_csb_o  <= 1'b0;
                sram_web_o  <= op_read;
                sram_addr_o <= cur_addr;
                sram_din_o  <= op_data;
                rd_q        <= op_read;
                exp_q       <= op_data;
                state       <= S_RUN;
                elem        <= cur_elem;
                sub         <= 1'b0;
                addr        <= cur_addr;
                if (!last_sub) begin
                    sub <= 1'b1;
                end else if (!addr_end) begin
                    addr <= op_down ? cur_addr - ADDR_WIDTH'(1) : cur_addr + ADDR_WIDTH'(1);
                end else if (!last_elem) begin
                    elem <= cur_elem + 3'd1;
                    addr <= nxt_down ? LAST_ADDR : '0;
                end else begin
                    state     <= S_DRAIN;
                    drain_cnt <= DCW'(READ_LATENCY);
                end
            end else if (state == S_RUN) begin
                // Abort one edge after the last issued op, so one fewer drain cycle keeps the same tail.
                state     <= S_DRAIN;
                drain_cnt <= DCW'(READ_LATENCY - 1);
            end else if (state == S_DRAIN) begin
                if (drain_cnt == '0) begin
                    state  <= S_DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt - DCW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - directed vector bench for sram_march_bist with behavioural SRAM models
module tb_sram_march_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        stop = 1'b0;
    bit          sel = 1'b0;
    bit          f_en = 1'b0;
    int          f_addr = 0, f_bit = 0;
    bit          f_val = 1'b0;

    logic        a_csb, a_web, a_busy, a_done, a_fail;
    logic [3:0]  a_wmask;
    logic [7:0]  a_addr, a_ffa;
    logic [31:0] a_din, a_dout, a_ffd;
    logic [15:0] a_err;
    logic        b_csb, b_web, b_busy, b_done, b_fail;
    logic [3:0]  b_wmask;
    logic [7:0]  b_addr, b_ffa;
    logic [31:0] b_din, b_dout, b_ffd, b_d1, b_d2;
    logic [15:0] b_err;

    sram_march_bist #(.DEPTH(16), .READ_LATENCY(1)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a), .mode_i(mode), .stop_on_fail_i(stop),
        .sram_csb_o(a_csb), .sram_web_o(a_web), .sram_wmask_o(a_wmask), .sram_addr_o(a_addr),
        .sram_din_o(a_din), .sram_dout_i(a_dout), .busy_o(a_busy), .done_o(a_done), .fail_o(a_fail),
        .err_count_o(a_err), .first_fail_addr_o(a_ffa), .first_fail_data_o(a_ffd));

    sram_march_bist #(.DEPTH(4), .READ_LATENCY(3)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b), .mode_i(mode), .stop_on_fail_i(stop),
        .sram_csb_o(b_csb), .sram_web_o(b_web), .sram_wmask_o(b_wmask), .sram_addr_o(b_addr),
        .sram_din_o(b_din), .sram_dout_i(b_dout), .busy_o(b_busy), .done_o(b_done), .fail_o(b_fail),
        .err_count_o(b_err), .first_fail_addr_o(b_ffa), .first_fail_data_o(b_ffd));

    function automatic logic [31:0] fault_rd(input logic [31:0] d, input int a);
        logic [31:0] r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [4];
    always @(posedge clk) begin
        if (!a_csb) begin
            if (!a_web) mem_a[a_addr[3:0]] <= a_din;
            else        a_dout <= fault_rd(mem_a[a_addr[3:0]], int'(a_addr));
        end
        b_d2   <= b_d1;
        b_dout <= b_d2;
        if (!b_csb) begin
            if (!b_web) mem_b[b_addr[1:0]] <= b_din;
            else        b_d1 <= fault_rd(mem_b[b_addr[1:0]], int'(b_addr));
        end
    end

    wire        s_csb  = sel ? b_csb  : a_csb;
    wire        s_web  = sel ? b_web  : a_web;
    wire        s_busy = sel ? b_busy : a_busy;
    wire        s_done = sel ? b_done : a_done;
    wire        s_fail = sel ? b_fail : a_fail;
    wire [7:0]  s_addr = sel ? b_addr : a_addr;
    wire [7:0]  s_ffa  = sel ? b_ffa  : a_ffa;
    wire [31:0] s_din  = sel ? b_din  : a_din;
    wire [31:0] s_ffd  = sel ? b_ffd  : a_ffd;
    wire [15:0] s_err  = sel ? b_err  : a_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int          n_ops, first_op, last_op, done_cyc, busy_bad;
    logic [7:0]  q_addr[$];
    logic        q_web[$];
    logic [31:0] q_din[$];

    // Accept at cycle 0; loop index c is the cycle number seen on each falling edge afterwards.
    task automatic run(input bit s, input logic [1:0] m, input bit stp, input int inj, input int max_c);
        n_ops = 0; first_op = -1; last_op = -1; done_cyc = -1; busy_bad = 0;
        q_addr.delete(); q_web.delete(); q_din.delete();
        @(negedge clk);
        sel = s; mode = m; stop = stp;
        start_a = !s; start_b = s;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            if (!s_csb) begin
                n_ops++;
                if (first_op < 0) first_op = c;
                last_op = c;
                q_addr.push_back(s_addr); q_web.push_back(s_web); q_din.push_back(s_din);
            end
            if (s_done) begin
                if (s_busy) busy_bad++;
                done_cyc = c;
                break;
            end
            if (!s_busy) busy_bad++;
            if (c == inj) mode = 2'd2;
            start_a = (c == inj) && !s;
            start_b = (c == inj) && s;
            if (c < max_c) @(negedge clk);
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    typedef struct {
        bit          s;
        logic [1:0]  m;
        bit          stp;
        bit          fen;
        int          fa;
        int          fb;
        bit          fv;
        int          inj;
        int          ops;
        int          last;
        int          done;
        bit          fail;
        int          err;
        int          ffa;
        logic [31:0] ffd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 2'd0, 0, 0, 0, 0, 0, 0,  160, 160, 162, 0, 0, 0, 32'h0};
        vecs[1]  = '{0, 2'd0, 0, 1, 5, 3, 1, 0,  160, 160, 162, 1, 3, 5, 32'h00000008};
        vecs[2]  = '{0, 2'd0, 1, 1, 5, 3, 1, 0,  28,  28,  30,  1, 1, 5, 32'h00000008};
        vecs[3]  = '{0, 2'd1, 0, 1, 2, 0, 0, 0,  64,  64,  66,  1, 1, 2, 32'h55555554};
        vecs[4]  = '{0, 2'd2, 0, 0, 0, 0, 0, 0,  32,  32,  34,  0, 0, 0, 32'h0};
        vecs[5]  = '{0, 2'd3, 0, 0, 0, 0, 0, 50, 160, 160, 162, 0, 0, 0, 32'h0};
        vecs[6]  = '{0, 2'd2, 0, 1, 5, 31, 1, 0, 32,  32,  34,  1, 1, 5, 32'h80000005};
        vecs[7]  = '{1, 2'd2, 0, 0, 0, 0, 0, 0,  8,   8,   12,  0, 0, 0, 32'h0};
        vecs[8]  = '{1, 2'd0, 0, 0, 0, 0, 0, 0,  40,  40,  44,  0, 0, 0, 32'h0};
        vecs[9]  = '{1, 2'd0, 0, 1, 3, 0, 1, 0,  40,  40,  44,  1, 3, 3, 32'h00000001};
        vecs[10] = '{1, 2'd0, 1, 1, 3, 0, 1, 0,  14,  14,  18,  1, 1, 3, 32'h00000001};

        repeat (3) @(negedge clk);
        chk("rst csb", a_csb, 1);
        chk("rst web", a_web, 1);
        chk("rst wmask", a_wmask, 4'hF);
        chk("rst status", {a_busy, a_done, a_fail}, 0);
        chk("rst err", a_err, 0);
        chk("rst addr/din", {a_addr, a_din}, 0);
        chk("rst first_fail", {a_ffa, a_ffd}, 0);
        chk("rst b csb/web", {b_csb, b_web, b_busy, b_done}, 4'b1100);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            f_en = vecs[i].fen; f_addr = vecs[i].fa; f_bit = vecs[i].fb; f_val = vecs[i].fv;
            run(vecs[i].s, vecs[i].m, vecs[i].stp, vecs[i].inj, 400);
            chk($sformatf("v%0d ops", i), n_ops, vecs[i].ops);
            chk($sformatf("v%0d first_op", i), first_op, 1);
            chk($sformatf("v%0d last_op", i), last_op, vecs[i].last);
            chk($sformatf("v%0d done_cycle", i), done_cyc, vecs[i].done);
            chk($sformatf("v%0d busy", i), busy_bad, 0);
            chk($sformatf("v%0d fail", i), s_fail, vecs[i].fail);
            chk($sformatf("v%0d err_count", i), s_err, vecs[i].err);
            chk($sformatf("v%0d first_addr", i), s_ffa, vecs[i].ffa);
            chk($sformatf("v%0d first_data", i), s_ffd, vecs[i].ffd);
            if (i == 0 && n_ops == 160) begin
                chk("march op1", {q_addr[0], q_web[0]}, {8'd0, 1'b0});
                chk("march e3 start r", {q_addr[80], q_web[80]}, {8'd15, 1'b1});
                chk("march e3 start w", {q_addr[81], q_web[81]}, {8'd15, 1'b0});
                chk("march e3 end", {q_addr[110], q_addr[111]}, {8'd0, 8'd0});
                chk("march e4 start", q_addr[112], 15);
                chk("march e4 end", q_addr[143], 0);
                chk("march e5 start", {q_addr[144], q_web[144]}, {8'd0, 1'b1});
            end
            if (i == 3 && n_ops == 64) begin
                chk("cb w P a0", q_din[0], 32'h55555555);
                chk("cb w P a1", q_din[1], 32'hAAAAAAAA);
                chk("cb r P", q_web[16], 1);
                chk("cb w ~P a0", q_din[32], 32'hAAAAAAAA);
            end
        end

        f_en = 1'b1; f_addr = 5; f_bit = 3; f_val = 1'b1;
        run(0, 2'd0, 0, 0, 60);
        chk("pre-reset err", a_err, 1);
        chk("pre-reset busy", a_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-reset csb", a_csb, 1);
        chk("mid-reset busy", a_busy, 0);
        chk("mid-reset err", a_err, 0);
        chk("mid-reset fail/done", {a_fail, a_done}, 0);
        rst = 1'b0;

        f_en = 1'b0;
        run(0, 2'd2, 0, 0, 400);
        chk("recover ops", n_ops, 32);
        chk("recover done_cycle", done_cyc, 34);
        repeat (3) @(negedge clk);
        chk("done held", {a_done, a_busy, a_csb}, 3'b101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
